shift_arb: RTL and testbench
============================

SHIFT_ARB -- requirements
Module: shift_arb

Interface
REQ-001 Parameter TAG_W, default 4, SHALL set the width of the request/response tag.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-004 req0_valid / req1_valid  input  1  SHALL flag a pending request from requester 0 / 1.
REQ-005 req0_ready / req1_ready  output  1  SHALL flag that the request is accepted this cycle.
REQ-006 req0_a / req1_a  input  32  SHALL carry the operand to shift.
REQ-007 req0_shamt / req1_shamt  input  5  SHALL carry the shift amount.
REQ-008 req0_op / req1_op  input  2  SHALL select the operation: 00 SLL, 01 SRL, 10 SRA, 11 illegal.
REQ-009 req0_tag / req1_tag  input  TAG_W  SHALL carry an opaque tag returned with the result.
REQ-010 rsp_valid  output  1  SHALL flag a held result.
REQ-011 rsp_ready  input  1  SHALL flag that the consumer takes the result this cycle.
REQ-012 rsp_result  output  32  SHALL carry the shift result.
REQ-013 rsp_id  output  1  SHALL identify the requester that issued the result.
REQ-014 rsp_tag  output  TAG_W  SHALL return the accepted request's tag.
REQ-015 rsp_err  output  1  SHALL flag that the result came from an illegal op.

Function
REQ-016 The block SHALL share one shift datapath between two requesters using valid/ready handshakes on both sides.
REQ-017 The FSM SHALL have two states: IDLE (no result held) and HOLD (result held, rsp_valid=1).
REQ-018 The block SHALL accept a request when (state==IDLE or rsp_ready=1) and that requester's valid=1 and it holds the grant.
REQ-019 Each reqN_ready SHALL be 1 exactly in the cycle its request is granted and accepted; both readys SHALL never be 1 together.
REQ-020 Arbitration SHALL be round-robin: with both valid, the requester not granted last SHALL win; with one valid, that one SHALL win.
REQ-021 The last-grant pointer SHALL update only on an accepted request.
REQ-022 On acceptance, a, shamt, op, tag and id SHALL be registered; the next cycle state SHALL be HOLD with rsp_valid=1 (latency 1 cycle).
REQ-023 rsp_result SHALL be computed from the registered operands: SLL zero-fill, SRL zero-fill, SRA sign-fill from a[31], shamt 0 returns a unchanged.
REQ-024 Op 11 SHALL produce rsp_result=0 and rsp_err=1; legal ops SHALL produce rsp_err=0.
REQ-025 While rsp_valid=1 and rsp_ready=0, rsp_result, rsp_id, rsp_tag and rsp_err SHALL hold stable and no request SHALL be accepted.
REQ-026 On rsp_ready=1 in HOLD with a valid request, the new request SHALL be accepted the same cycle, giving throughput of one result per cycle.
REQ-027 On rsp_ready=1 in HOLD with no valid request, the next state SHALL be IDLE with rsp_valid=0.
REQ-028 rsp_ready in IDLE SHALL be ignored.
REQ-029 Request inputs SHALL be sampled only in the accept cycle; later changes SHALL not affect the held result.

Reset
REQ-030 rst=1 SHALL immediately force state IDLE, rsp_valid=0, rsp_result=0, rsp_id=0, rsp_tag=0, rsp_err=0, and last-grant=1 (requester 0 wins the first tie).
REQ-031 req0_ready and req1_ready SHALL be 0 while rst=1.
REQ-032 Reset during HOLD SHALL discard the held result without a handshake.

Structure
REQ-033 Shared package shift_pkg SHALL hold the op encodings (SH_SLL, SH_SRL, SH_SRA, SH_ILL) and the state enum.
REQ-034 The block SHALL instantiate one existing shift_unit as its only sub-module: operand to a, shamt zero-extended to 32 bits on b, op to shift_choose.

Verification
REQ-035 req0 SLL a=0x00000001 shamt=31 tag=3 -> next cycle rsp_valid=1, rsp_result=0x80000000, rsp_id=0, rsp_tag=3.
REQ-036 req1 SRA a=0x80000000 shamt=4 -> 0xF8000000; then SRL with the same operands -> 0x08000000, rsp_id=1.
REQ-037 Both valid right after reset with rsp_ready=1 -> req0 granted, then req1 the next cycle; results in consecutive cycles with ids 0 then 1.
REQ-038 rsp_ready held 0 for 3 cycles with both valid -> outputs stable, both readys 0, no grant; on rsp_ready=1, the next requester is accepted the same cycle.
REQ-039 Op=11 a=0xFFFFFFFF -> rsp_result=0, rsp_err=1.
REQ-040 rst asserted mid-HOLD -> rsp_valid=0 with no clock edge; after release, req0 wins the first tie.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared definitions for the shift arbiter: op encodings, FSM state type, widths.
package shift_pkg;

  localparam int unsigned DataW  = 32;
  localparam int unsigned ShamtW = 5;
  localparam int unsigned OpW    = 2;

  // Operation select carried with every request
  typedef enum logic [OpW-1:0] {
    SH_SLL = 2'b00,
    SH_SRL = 2'b01,
    SH_SRA = 2'b10,
    SH_ILL = 2'b11
  } shift_op_e;

  // IDLE: nothing held; HOLD: result presented on the response port
  typedef enum logic {
    StIdle = 1'b0,
    StHold = 1'b1
  } arb_state_e;

  function automatic logic is_legal_op(shift_op_e op);
    return op != SH_ILL;
  endfunction

endpackage

// File: rtl/shift_arb_if.sv
// Request/response bundle for shift_arb: two requesters in, one response out.
interface shift_arb_if
  import shift_pkg::*;
#(
  parameter int unsigned TAG_W = 4
);

  // Requester 0
  logic                 req0_valid;
  logic                 req0_ready;
  logic [DataW-1:0]     req0_a;
  logic [ShamtW-1:0]    req0_shamt;
  logic [OpW-1:0]       req0_op;
  logic [TAG_W-1:0]     req0_tag;

  // Requester 1
  logic                 req1_valid;
  logic                 req1_ready;
  logic [DataW-1:0]     req1_a;
  logic [ShamtW-1:0]    req1_shamt;
  logic [OpW-1:0]       req1_op;
  logic [TAG_W-1:0]     req1_tag;

  // Response
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [DataW-1:0]     rsp_result;
  logic                 rsp_id;
  logic [TAG_W-1:0]     rsp_tag;
  logic                 rsp_err;

  // Requesters and response consumer
  modport master (
    output req0_valid, req0_a, req0_shamt, req0_op, req0_tag,
    output req1_valid, req1_a, req1_shamt, req1_op, req1_tag,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_result, rsp_id, rsp_tag, rsp_err
  );

  // The arbiter itself
  modport slave (
    input  req0_valid, req0_a, req0_shamt, req0_op, req0_tag,
    input  req1_valid, req1_a, req1_shamt, req1_op, req1_tag,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_result, rsp_id, rsp_tag, rsp_err
  );

endinterface

// File: rtl/shift_unit.sv
// Combinational 32-bit shifter: SLL/SRL zero-fill, SRA sign-fill, illegal op yields 0.
module shift_unit
  import shift_pkg::*;
(
  input  logic [DataW-1:0] a,
  input  logic [DataW-1:0] b,
  input  shift_op_e        shift_choose,
  output logic [DataW-1:0] result
);

  // Select the shift flavour; b never exceeds 31 since callers zero-extend a 5-bit amount
  always_comb begin
    result = '0;
    case (shift_choose)
      SH_SLL: result = a << b;
      SH_SRL: result = a >> b;
      SH_SRA: result = $signed(a) >>> b;
      SH_ILL: result = '0;
    endcase
  end

endmodule

// File: rtl/shift_arb.sv
// Round-robin arbiter sharing one shifter between two valid/ready requesters.
// A granted request is registered and its result presented one cycle later; a new
// request may be taken in the same cycle the held result is consumed.
module shift_arb
  import shift_pkg::*;
#(
  parameter int unsigned TAG_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  shift_arb_if.slave  bus
);

  arb_state_e         r_state;
  arb_state_e         w_state_next;

  // Id of the requester granted most recently; 1 at reset so requester 0 wins the first tie
  logic               r_last;

  // Operands captured at acceptance
  logic [DataW-1:0]   r_a;
  logic [ShamtW-1:0]  r_shamt;
  shift_op_e          r_op;
  logic [TAG_W-1:0]   r_tag;
  logic               r_id;

  logic               w_can_accept;
  logic               w_gnt0;
  logic               w_gnt1;
  logic               w_ready0;
  logic               w_ready1;
  logic               w_accept;

  logic [DataW-1:0]   w_sel_a;
  logic [ShamtW-1:0]  w_sel_shamt;
  logic [OpW-1:0]     w_sel_op;
  logic [TAG_W-1:0]   w_sel_tag;

  logic [DataW-1:0]   w_shift_result;

  // Grant, handshake and next-state decision
  always_comb begin
    w_state_next = r_state;
    w_ready0     = 1'b0;
    w_ready1     = 1'b0;

    // Slot is free when nothing is held or the held result leaves this cycle
    w_can_accept = (r_state == StIdle) || bus.rsp_ready;

    // With both valid the requester not granted last wins
    w_gnt0 = bus.req0_valid && (!bus.req1_valid || r_last);
    w_gnt1 = bus.req1_valid && (!bus.req0_valid || !r_last);

    // Ready is masked while reset is asserted, since reset is asynchronous
    if (!rst && w_can_accept) begin
      w_ready0 = w_gnt0;
      w_ready1 = w_gnt1;
    end
    w_accept = w_ready0 | w_ready1;

    unique case (r_state)
      StIdle: begin
        if (w_accept) w_state_next = StHold;
      end
      StHold: begin
        if (w_accept) begin
          w_state_next = StHold;
        end else if (bus.rsp_ready) begin
          w_state_next = StIdle;
        end
      end
    endcase
  end

  // Operand mux steered by the grant
  always_comb begin
    w_sel_a     = bus.req0_a;
    w_sel_shamt = bus.req0_shamt;
    w_sel_op    = bus.req0_op;
    w_sel_tag   = bus.req0_tag;
    if (w_gnt1) begin
      w_sel_a     = bus.req1_a;
      w_sel_shamt = bus.req1_shamt;
      w_sel_op    = bus.req1_op;
      w_sel_tag   = bus.req1_tag;
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Capture the accepted request and remember who was granted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last  <= 1'b1;
      r_a     <= '0;
      r_shamt <= '0;
      r_op    <= SH_SLL;
      r_tag   <= '0;
      r_id    <= 1'b0;
    end else if (w_accept) begin
      r_last  <= w_ready1;
      r_a     <= w_sel_a;
      r_shamt <= w_sel_shamt;
      r_op    <= shift_op_e'(w_sel_op);
      r_tag   <= w_sel_tag;
      r_id    <= w_ready1;
    end
  end

  // Cleared operands (a=0, SLL) make the reset-time result 0 without extra muxing
  shift_unit u_shift_unit (
    .a            (r_a),
    .b            ({{(DataW-ShamtW){1'b0}}, r_shamt}),
    .shift_choose (r_op),
    .result       (w_shift_result)
  );

  assign bus.req0_ready = w_ready0;
  assign bus.req1_ready = w_ready1;
  assign bus.rsp_valid  = (r_state == StHold);
  assign bus.rsp_result = w_shift_result;
  assign bus.rsp_id     = r_id;
  assign bus.rsp_tag    = r_tag;
  assign bus.rsp_err    = !is_legal_op(r_op);

endmodule

// File: tb/tb_shift_arb.sv
// Self-checking bench for shift_arb: directed vector table, hand sequences, random vs model.
module tb_shift_arb;
  import shift_pkg::*;

  localparam int unsigned TW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  shift_arb_if #(.TAG_W(TW)) bus ();

  shift_arb #(.TAG_W(TW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: what the response port should hold, and who was granted last
  logic          m_valid;
  logic [31:0]   m_result;
  logic          m_id;
  logic [TW-1:0] m_tag;
  logic          m_err;
  logic          m_last;

  typedef struct {
    logic          v0;
    logic [31:0]   a0;
    logic [4:0]    s0;
    logic [1:0]    op0;
    logic [TW-1:0] t0;
    logic          v1;
    logic [31:0]   a1;
    logic [4:0]    s1;
    logic [1:0]    op1;
    logic [TW-1:0] t1;
    logic          rr;
    logic          e_r0;
    logic          e_r1;
    logic          e_v;
    logic [31:0]   e_res;
    logic          e_id;
    logic [TW-1:0] e_tag;
    logic          e_err;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Shift computed as multiplication/division by a power of two
  function automatic logic [31:0] ref_shift(input logic [31:0] a, input logic [4:0] s,
                                            input logic [1:0] op);
    logic [31:0] p;
    logic [63:0] prod;
    p    = 32'd1 << s;
    prod = 64'(a) * 64'(p);
    case (op)
      2'd0:    return prod[31:0];
      2'd1:    return a / p;
      2'd2:    return a[31] ? ~((~a) / p) : (a / p);
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_valid  = 1'b0;
    m_result = '0;
    m_id     = 1'b0;
    m_tag    = '0;
    m_err    = 1'b0;
    m_last   = 1'b1;
  endtask

  task automatic set_req0(input logic v, input logic [31:0] a, input logic [4:0] s,
                          input logic [1:0] op, input logic [TW-1:0] t);
    bus.req0_valid = v; bus.req0_a = a; bus.req0_shamt = s; bus.req0_op = op; bus.req0_tag = t;
  endtask

  task automatic set_req1(input logic v, input logic [31:0] a, input logic [4:0] s,
                          input logic [1:0] op, input logic [TW-1:0] t);
    bus.req1_valid = v; bus.req1_a = a; bus.req1_shamt = s; bus.req1_op = op; bus.req1_tag = t;
  endtask

  // Called at a negedge with inputs already driven; returns at the next negedge
  task automatic tick(output logic r0, output logic r1);
    logic free, g0, g1, e0, e1;
    #1;
    r0   = bus.req0_ready;
    r1   = bus.req1_ready;
    free = !m_valid || bus.rsp_ready;
    g0   = bus.req0_valid && (!bus.req1_valid || m_last == 1'b1);
    g1   = bus.req1_valid && (!bus.req0_valid || m_last == 1'b0);
    e0   = free && g0;
    e1   = free && g1;
    chk("req0_ready", 32'(r0), 32'(e0));
    chk("req1_ready", 32'(r1), 32'(e1));
    @(posedge clk);
    if (e0 || e1) begin
      m_valid  = 1'b1;
      m_id     = e1;
      m_last   = e1;
      m_tag    = e1 ? bus.req1_tag : bus.req0_tag;
      m_err    = (e1 ? bus.req1_op : bus.req0_op) == 2'b11;
      m_result = e1 ? ref_shift(bus.req1_a, bus.req1_shamt, bus.req1_op)
                    : ref_shift(bus.req0_a, bus.req0_shamt, bus.req0_op);
    end else if (m_valid && bus.rsp_ready) begin
      m_valid = 1'b0;
    end
    @(negedge clk);
    chk("rsp_valid", 32'(bus.rsp_valid), 32'(m_valid));
    if (m_valid) begin
      chk("rsp_result", bus.rsp_result, m_result);
      chk("rsp_id", 32'(bus.rsp_id), 32'(m_id));
      chk("rsp_tag", 32'(bus.rsp_tag), 32'(m_tag));
      chk("rsp_err", 32'(bus.rsp_err), 32'(m_err));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic r0, r1;

    //                 v0  a0            s0     op0    t0     v1  a1            s1     op1    t1
    //                 rr  er0 er1 ev  res           id  tag    err
    vecs[0]  = '{1'b1, 32'h0000_0001, 5'd31, 2'b00, 4'd3, 1'b0, 32'h0, 5'd0, 2'b00, 4'd0,
                 1'b1, 1'b1, 1'b0, 1'b1, 32'h8000_0000, 1'b0, 4'd3, 1'b0};
    vecs[1]  = '{1'b0, 32'h0, 5'd0, 2'b00, 4'd0, 1'b1, 32'h8000_0000, 5'd4, 2'b10, 4'd5,
                 1'b1, 1'b0, 1'b1, 1'b1, 32'hF800_0000, 1'b1, 4'd5, 1'b0};
    vecs[2]  = '{1'b0, 32'h0, 5'd0, 2'b00, 4'd0, 1'b1, 32'h8000_0000, 5'd4, 2'b01, 4'd6,
                 1'b1, 1'b0, 1'b1, 1'b1, 32'h0800_0000, 1'b1, 4'd6, 1'b0};
    vecs[3]  = '{1'b1, 32'hFFFF_FFFF, 5'd7, 2'b11, 4'd9, 1'b0, 32'h0, 5'd0, 2'b00, 4'd0,
                 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 4'd9, 1'b1};
    vecs[4]  = '{1'b0, 32'h0, 5'd0, 2'b00, 4'd0, 1'b0, 32'h0, 5'd0, 2'b00, 4'd0,
                 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 4'd0, 1'b0};
    vecs[5]  = '{1'b1, 32'h1234_5678, 5'd0, 2'b00, 4'd1, 1'b1, 32'h0000_00F0, 5'd4, 2'b01, 4'd2,
                 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_000F, 1'b1, 4'd2, 1'b0};
    vecs[6]  = '{1'b1, 32'h1234_5678, 5'd0, 2'b00, 4'd1, 1'b1, 32'h0000_00F0, 5'd4, 2'b01, 4'd2,
                 1'b1, 1'b1, 1'b0, 1'b1, 32'h1234_5678, 1'b0, 4'd1, 1'b0};
    vecs[7]  = '{1'b1, 32'h1234_5678, 5'd0, 2'b00, 4'd1, 1'b1, 32'h0000_00F0, 5'd4, 2'b01, 4'd2,
                 1'b0, 1'b0, 1'b0, 1'b1, 32'h1234_5678, 1'b0, 4'd1, 1'b0};
    vecs[8]  = '{1'b1, 32'h7FFF_FFFF, 5'd1, 2'b10, 4'd4, 1'b0, 32'h0, 5'd0, 2'b00, 4'd0,
                 1'b1, 1'b1, 1'b0, 1'b1, 32'h3FFF_FFFF, 1'b0, 4'd4, 1'b0};
    vecs[9]  = '{1'b0, 32'h0, 5'd0, 2'b00, 4'd0, 1'b0, 32'h0, 5'd0, 2'b00, 4'd0,
                 1'b0, 1'b0, 1'b0, 1'b1, 32'h3FFF_FFFF, 1'b0, 4'd4, 1'b0};
    vecs[10] = '{1'b0, 32'h0, 5'd0, 2'b00, 4'd0, 1'b0, 32'h0, 5'd0, 2'b00, 4'd0,
                 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 4'd0, 1'b0};

    // Reset state, with a request pending that must not be acknowledged
    rst = 1'b1;
    bus.rsp_ready = 1'b0;
    set_req0(1'b1, 32'h1, 5'd1, 2'b00, 4'd1);
    set_req1(1'b1, 32'h2, 5'd1, 2'b00, 4'd2);
    model_reset();
    @(negedge clk);
    #1;
    chk("reset_req0_ready", 32'(bus.req0_ready), 32'd0);
    chk("reset_req1_ready", 32'(bus.req1_ready), 32'd0);
    chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("reset_rsp_result", bus.rsp_result, 32'd0);
    chk("reset_rsp_id", 32'(bus.rsp_id), 32'd0);
    chk("reset_rsp_tag", 32'(bus.rsp_tag), 32'd0);
    chk("reset_rsp_err", 32'(bus.rsp_err), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Both valid straight out of reset: req0 first, req1 next, back to back
    set_req0(1'b1, 32'h0000_0003, 5'd2, 2'b00, 4'd1);
    set_req1(1'b1, 32'h0000_0100, 5'd8, 2'b01, 4'd2);
    bus.rsp_ready = 1'b1;
    tick(r0, r1);
    chk("tie0_grant0", 32'({r0, r1}), 32'b10);
    chk("tie0_id", 32'(bus.rsp_id), 32'd0);
    chk("tie0_result", bus.rsp_result, 32'h0000_000C);
    tick(r0, r1);
    chk("tie1_grant1", 32'({r0, r1}), 32'b01);
    chk("tie1_id", 32'(bus.rsp_id), 32'd1);
    chk("tie1_result", bus.rsp_result, 32'h0000_0001);

    // Back-pressure for three cycles; changed inputs must not disturb the held result
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) set_req1(1'b1, 32'hFFFF_0000, 5'd3, 2'b10, 4'd7);
      tick(r0, r1);
      chk("stall_readys", 32'({r0, r1}), 32'b00);
      chk("stall_valid", 32'(bus.rsp_valid), 32'd1);
      chk("stall_result", bus.rsp_result, 32'h0000_0001);
      chk("stall_id", 32'(bus.rsp_id), 32'd1);
      chk("stall_tag", 32'(bus.rsp_tag), 32'd2);
    end
    bus.rsp_ready = 1'b1;
    tick(r0, r1);
    chk("unstall_grant0", 32'({r0, r1}), 32'b10);
    chk("unstall_id", 32'(bus.rsp_id), 32'd0);

    // Asynchronous reset while a result is held
    set_req1(1'b0, 32'h0, 5'd0, 2'b00, 4'd0);
    set_req0(1'b1, 32'h0000_0005, 5'd1, 2'b00, 4'd7);
    tick(r0, r1);
    chk("pre_rst_valid", 32'(bus.rsp_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(bus.rsp_valid), 32'd0);
    chk("async_rst_result", bus.rsp_result, 32'd0);
    chk("async_rst_tag", 32'(bus.rsp_tag), 32'd0);
    chk("async_rst_req0_ready", 32'(bus.req0_ready), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    set_req0(1'b1, 32'h0000_0010, 5'd4, 2'b01, 4'd8);
    set_req1(1'b1, 32'h0000_0020, 5'd4, 2'b01, 4'd9);
    bus.rsp_ready = 1'b0;
    tick(r0, r1);
    chk("post_rst_tie_grant0", 32'({r0, r1}), 32'b10);
    chk("post_rst_tie_id", 32'(bus.rsp_id), 32'd0);

    // Drain to IDLE before the vector table
    set_req0(1'b0, 32'h0, 5'd0, 2'b00, 4'd0);
    set_req1(1'b0, 32'h0, 5'd0, 2'b00, 4'd0);
    bus.rsp_ready = 1'b1;
    tick(r0, r1);

    for (int i = 0; i < 11; i++) begin
      set_req0(vecs[i].v0, vecs[i].a0, vecs[i].s0, vecs[i].op0, vecs[i].t0);
      set_req1(vecs[i].v1, vecs[i].a1, vecs[i].s1, vecs[i].op1, vecs[i].t1);
      bus.rsp_ready = vecs[i].rr;
      tick(r0, r1);
      chk($sformatf("vec%0d_readys", i), 32'({r0, r1}), 32'({vecs[i].e_r0, vecs[i].e_r1}));
      chk($sformatf("vec%0d_valid", i), 32'(bus.rsp_valid), 32'(vecs[i].e_v));
      if (vecs[i].e_v) begin
        chk($sformatf("vec%0d_result", i), bus.rsp_result, vecs[i].e_res);
        chk($sformatf("vec%0d_id", i), 32'(bus.rsp_id), 32'(vecs[i].e_id));
        chk($sformatf("vec%0d_tag", i), 32'(bus.rsp_tag), 32'(vecs[i].e_tag));
        chk($sformatf("vec%0d_err", i), 32'(bus.rsp_err), 32'(vecs[i].e_err));
      end
    end

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      set_req0($urandom_range(0, 9) < 7, $urandom, 5'($urandom_range(0, 31)),
               2'($urandom_range(0, 3)), TW'($urandom_range(0, 15)));
      set_req1($urandom_range(0, 9) < 7, $urandom, 5'($urandom_range(0, 31)),
               2'($urandom_range(0, 3)), TW'($urandom_range(0, 15)));
      bus.rsp_ready = $urandom_range(0, 9) < 6;
      tick(r0, r1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
